// File: rtl/led_blink_if.sv
// led_blink_if: start/code/repeat request and LED status bundle for led_blink_code
interface led_blink_if;
  logic       i_start;
  logic [3:0] i_code;
  logic       i_repeat;
  logic       o_led;
  logic       o_busy;
  logic       o_done;
  modport master (output i_start, i_code, i_repeat, input o_led, o_busy, o_done);
  modport slave (input i_start, i_code, i_repeat, output o_led, o_busy, o_done);
endinterface

// File: rtl/led_blink_code.sv
// led_blink_code: drives an LED with N on/off blinks then a dark gap, optionally repeating
module led_blink_code #(
  parameter int c_on_limit    = 5000000,
  parameter int c_off_limit   = 5000000,
  parameter int c_gap_limit   = 25000000,
  parameter int c_count_width = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  led_blink_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;
  state_t                   r_state, w_next;
  logic [c_count_width-1:0] r_cnt, w_last;
  logic [3:0]               r_rem, r_code;
  logic                     r_led, r_busy, r_done, w_led, w_busy, w_done, w_start, w_end;
  assign w_start = bus.i_start && bus.i_code != 4'd0;
  assign w_last  = r_state == S_ON  ? c_count_width'(c_on_limit - 1) :
                   r_state == S_OFF ? c_count_width'(c_off_limit - 1) :
                                      c_count_width'(c_gap_limit - 1);
  assign w_end   = r_state != S_IDLE && r_cnt == w_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_code  <= '0;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_led   <= w_led;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= (r_state == S_IDLE || w_end) ? '0 : r_cnt + c_count_width'(1);
      r_code  <= (r_state == S_IDLE && w_start) ? bus.i_code : r_code;
      r_rem   <= (r_state == S_IDLE && w_start)             ? bus.i_code :
                 (r_state == S_ON && w_end)                 ? r_rem - 4'd1 :
                 (r_state == S_GAP && w_end && bus.i_repeat) ? r_code : r_rem;
    end
  end
  // r_rem == 1 at the end of ON means this was the last blink: skip OFF
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_start ? S_ON : S_IDLE;
      S_ON:   w_next = !w_end ? S_ON : (r_rem != 4'd1 ? S_OFF : S_GAP);
      S_OFF:  w_next = w_end ? S_ON : S_OFF;
      S_GAP:  w_next = !w_end ? S_GAP : (bus.i_repeat ? S_ON : S_IDLE);
    endcase
  end
  always_comb begin
    w_led  = w_next == S_ON;
    w_busy = w_next != S_IDLE;
    w_done = r_state == S_GAP && w_next == S_IDLE;
  end
  assign bus.o_led  = r_led;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_led_blink_code.sv
// tb_led_blink_code: randomized scoreboard bench comparing per-cycle LED/busy/done traces to a pattern model
module tb_led_blink_code;
  localparam int ON = 3, OFF = 2, GAP = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] exp_q[$];
  led_blink_if bus();
  led_blink_code #(.c_on_limit(ON), .c_off_limit(OFF), .c_gap_limit(GAP), .c_count_width(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic int pass_len(int n);
    return n * ON + (n - 1) * OFF + GAP;
  endfunction
  // expected {led,busy,done} per cycle for `passes` replays of code n, truncated to `limit` entries
  task automatic push_trace(int n, int passes, int limit);
    logic [2:0] t[$];
    for (int p = 0; p < passes; p++) begin
      for (int b = 1; b <= n; b++) begin
        repeat (ON) t.push_back(3'b110);
        if (b < n) repeat (OFF) t.push_back(3'b010);
      end
      repeat (GAP) t.push_back(3'b010);
    end
    t.push_back(3'b001);
    for (int i = 0; i < t.size() && (limit < 0 || i < limit); i++) exp_q.push_back(t[i]);
  endtask
  always @(negedge clk) begin
    if (rst_n && (bus.o_busy || bus.o_done)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got led/busy/done=%b, required idle", {bus.o_led, bus.o_busy, bus.o_done});
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if ({bus.o_led, bus.o_busy, bus.o_done} !== e) begin
          n_err++;
          $display("FAIL trace @%0t: got led/busy/done=%b, required %b", $time, {bus.o_led, bus.o_busy, bus.o_done}, e);
        end
      end
    end
  end
  task automatic drain(int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected cycles never seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic check_idle(string name);
    n_cmp++;
    if ({bus.o_led, bus.o_busy, bus.o_done} !== 3'b000) begin
      n_err++;
      $display("FAIL %s: got led/busy/done=%b, required 000", name, {bus.o_led, bus.o_busy, bus.o_done});
    end
  endtask
  task automatic run_txn(logic [3:0] code, int passes, bit inject);
    int len;
    len = pass_len(int'(code));
    if (code != 0) push_trace(int'(code), passes, -1);
    bus.i_code   = code;
    bus.i_repeat = passes > 1;
    bus.i_start  = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_code  = 4'($urandom);
    if (code == 0) begin
      repeat (4) @(posedge clk);
      #1;
      check_idle("zero_code_ignored");
      return;
    end
    for (int c = 1; c <= passes * len + 2 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
      if (inject && c == 1) begin
        bus.i_start = 1'b1;
        bus.i_code  = 4'($urandom_range(1, 15));
      end
      if (inject && c == 2) bus.i_start = 1'b0;
      if (passes > 1 && c == (passes - 1) * len + 1) bus.i_repeat = 1'b0;
    end
    drain(20);
  endtask
  initial begin
    bus.i_start  = 1'b0;
    bus.i_code   = 4'd0;
    bus.i_repeat = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_idle("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_txn(4'd3, 1, 1'b0);
    run_txn(4'd1, 1, 1'b0);
    run_txn(4'd0, 1, 1'b0);
    run_txn(4'd2, 1, 1'b1);
    run_txn(4'd2, 2, 1'b0);
    push_trace(4, 1, 11);
    bus.i_code  = 4'd4;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    drain(40);
    rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(posedge clk);
    #1 check_idle("held_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_txn(4'd1, 1, 1'b0);
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      run_txn(4'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 1'($urandom));
    end
    repeat (5) @(posedge clk);
    #1 check_idle("final_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
